// File: rtl/alu_seq_if.sv
// Instruction/result handshake bundle for the sequential ALU.
// The master issues instructions; the ALU slave returns results.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         iValid;
    logic         oReady;
    logic [3:0]   iOp;
    logic         iDest;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic         oValid;
    logic [W-1:0] oData;
    logic [W-1:0] oDataHi;
    logic         oWriteA;
    logic         oWriteB;
    logic         oRamEnableWrite;
    logic         oCa;
    logic         oCb;
    logic         oZero;

    modport master (
        output iValid, iOp, iDest, iA, iB,
        input  oReady, oValid, oData, oDataHi,
        input  oWriteA, oWriteB, oRamEnableWrite,
        input  oCa, oCb, oZero
    );

    modport slave (
        input  iValid, iOp, iDest, iA, iB,
        output oReady, oValid, oData, oDataHi,
        output oWriteA, oWriteB, oRamEnableWrite,
        output oCa, oCb, oZero
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with per-accumulator carry flags and a
// shift-add multiplier producing a 2W-bit product.
module alu_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 6
) (
    input logic  Clock,
    input logic  Reset,
    alu_seq_if.slave bus
);
    localparam logic [3:0] opAdd = 4'd0;
    localparam logic [3:0] opAdc = 4'd1;
    localparam logic [3:0] opSub = 4'd2;
    localparam logic [3:0] opSbc = 4'd3;
    localparam logic [3:0] opAnd = 4'd4;
    localparam logic [3:0] opOr  = 4'd5;
    localparam logic [3:0] opXor = 4'd6;
    localparam logic [3:0] opAsl = 4'd7;
    localparam logic [3:0] opLsr = 4'd8;
    localparam logic [3:0] opRol = 4'd9;
    localparam logic [3:0] opCmp = 4'd10;
    localparam logic [3:0] opSta = 4'd11;
    localparam logic [3:0] opMul = 4'd12;

    typedef enum logic [1:0] {
        stIdle,
        stMul,
        stDone
    } state_t;

    state_t         state;
    logic           ca;
    logic           cb;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CNT_W-1:0] cnt;
    logic           mulDest;

    logic           ready;
    logic           valid;
    logic [W-1:0]   data;
    logic [W-1:0]   dataHi;
    logic           writeA;
    logic           writeB;
    logic           ramWrite;
    logic           zero;

    logic [W-1:0]   p;
    logic [W-1:0]   q;
    logic           cIn;
    logic [W:0]     ext;
    logic [W-1:0]   res;
    logic           cOut;
    logic           regWrite;
    logic           ramOp;

    assign p   = bus.iDest ? bus.iB : bus.iA;
    assign q   = bus.iDest ? bus.iA : bus.iB;
    assign cIn = bus.iDest ? cb : ca;

    // Single-cycle datapath, evaluated on the acceptance cycle.
    always_comb begin
        ext      = '0;
        res      = '0;
        cOut     = cIn;
        regWrite = 1'b0;
        ramOp    = 1'b0;
        unique case (bus.iOp)
            opAdd: begin
                ext      = {1'b0, p} + {1'b0, q};
                res      = ext[W-1:0];
                cOut     = ext[W];
                regWrite = 1'b1;
            end
            opAdc: begin
                ext      = {1'b0, p} + {1'b0, q}
                         + {{W{1'b0}}, cIn};
                res      = ext[W-1:0];
                cOut     = ext[W];
                regWrite = 1'b1;
            end
            opSub, opCmp: begin
                ext      = {1'b0, p} - {1'b0, q};
                res      = ext[W-1:0];
                cOut     = ext[W];
                regWrite = (bus.iOp == opSub);
            end
            opSbc: begin
                ext      = {1'b0, p} - {1'b0, q}
                         - {{W{1'b0}}, cIn};
                res      = ext[W-1:0];
                cOut     = ext[W];
                regWrite = 1'b1;
            end
            opAnd: begin
                res      = p & q;
                regWrite = 1'b1;
            end
            opOr: begin
                res      = p | q;
                regWrite = 1'b1;
            end
            opXor: begin
                res      = p ^ q;
                regWrite = 1'b1;
            end
            opAsl: begin
                res      = {p[W-2:0], 1'b0};
                cOut     = p[W-1];
                regWrite = 1'b1;
            end
            opLsr: begin
                res      = {1'b0, p[W-1:1]};
                cOut     = p[0];
                regWrite = 1'b1;
            end
            opRol: begin
                res      = {p[W-2:0], cIn};
                cOut     = p[W-1];
                regWrite = 1'b1;
            end
            opSta: begin
                res   = p;
                ramOp = 1'b1;
            end
            opMul: begin
                regWrite = 1'b1;
            end
            default: begin
                res = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= stIdle;
            ca       <= 1'b0;
            cb       <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            mulDest  <= 1'b0;
            ready    <= 1'b1;
            valid    <= 1'b0;
            data     <= '0;
            dataHi   <= '0;
            writeA   <= 1'b0;
            writeB   <= 1'b0;
            ramWrite <= 1'b0;
            zero     <= 1'b0;
        end else begin
            valid    <= 1'b0;
            writeA   <= 1'b0;
            writeB   <= 1'b0;
            ramWrite <= 1'b0;
            unique case (state)
                stIdle, stDone: begin
                    ready <= 1'b1;
                    state <= stIdle;
                    if (bus.iValid && bus.iOp == opMul) begin
                        state   <= stMul;
                        ready   <= 1'b0;
                        acc     <= '0;
                        mcand   <= {{W{1'b0}}, p};
                        mplier  <= q;
                        cnt     <= '0;
                        mulDest <= bus.iDest;
                    end else if (bus.iValid) begin
                        valid    <= 1'b1;
                        data     <= res;
                        dataHi   <= '0;
                        zero     <= (res == '0);
                        writeA   <= regWrite & ~bus.iDest;
                        writeB   <= regWrite & bus.iDest;
                        ramWrite <= ramOp;
                        if (bus.iDest) cb <= cOut;
                        else           ca <= cOut;
                    end
                end
                stMul: begin
                    if (cnt == CNT_W'(W)) begin
                        state  <= stDone;
                        ready  <= 1'b1;
                        valid  <= 1'b1;
                        data   <= acc[W-1:0];
                        dataHi <= acc[2*W-1:W];
                        zero   <= (acc[W-1:0] == '0);
                        writeA <= ~mulDest;
                        writeB <= mulDest;
                        if (mulDest) cb <= |acc[2*W-1:W];
                        else         ca <= |acc[2*W-1:W];
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= stIdle;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.oReady         = ready;
    assign bus.oValid         = valid;
    assign bus.oData          = data;
    assign bus.oDataHi        = dataHi;
    assign bus.oWriteA        = writeA;
    assign bus.oWriteB        = writeB;
    assign bus.oRamEnableWrite = ramWrite;
    assign bus.oCa            = ca;
    assign bus.oCb            = cb;
    assign bus.oZero          = zero;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors at W=8 and W=16,
// expected results queued at issue time and matched by monitors.
module tb_alu_seq;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;
    int   nCmp  = 0;
    int   nErr  = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    alu_seq_if #(.W(8))  bus8 ();
    alu_seq_if #(.W(16)) bus16 ();

    alu_seq #(.W(8), .CNT_W(6)) dut8 (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus8)
    );

    alu_seq #(.W(16), .CNT_W(6)) dut16 (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus16)
    );

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [15:0] hi;
        logic        wa, wb, ram, ca, cb, z;
        string       tag;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    function automatic exp_t ex(input string tag,
                                input logic [15:0] d, hi,
                                input logic wa, wb, ram,
                                input logic ca, cb, z);
        exp_t e;
        e.cyc = 0;
        e.tag = tag;
        e.d   = d;
        e.hi  = hi;
        e.wa  = wa;
        e.wb  = wb;
        e.ram = ram;
        e.ca  = ca;
        e.cb  = cb;
        e.z   = z;
        return e;
    endfunction

    task automatic cmpOut(input exp_t e, input int c,
                          input logic [15:0] d, hi,
                          input logic wa, wb, ram,
                          input logic ca, cb, z);
        chk({e.tag, ".cycle"}, c, e.cyc);
        chk({e.tag, ".oData"}, {16'h0, d}, {16'h0, e.d});
        chk({e.tag, ".oDataHi"}, {16'h0, hi}, {16'h0, e.hi});
        chk({e.tag, ".oWriteA"}, {31'h0, wa}, {31'h0, e.wa});
        chk({e.tag, ".oWriteB"}, {31'h0, wb}, {31'h0, e.wb});
        chk({e.tag, ".oRamWr"}, {31'h0, ram}, {31'h0, e.ram});
        chk({e.tag, ".oCa"}, {31'h0, ca}, {31'h0, e.ca});
        chk({e.tag, ".oCb"}, {31'h0, cb}, {31'h0, e.cb});
        chk({e.tag, ".oZero"}, {31'h0, z}, {31'h0, e.z});
    endtask

    initial begin : mon8
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (bus8.oValid === 1'b1) begin
                if (q8.size() == 0) begin
                    chk("spurious8.oValid",
                        {31'h0, bus8.oValid}, 32'h0);
                end else begin
                    e = q8.pop_front();
                    cmpOut(e, cyc, {8'h0, bus8.oData},
                           {8'h0, bus8.oDataHi},
                           bus8.oWriteA, bus8.oWriteB,
                           bus8.oRamEnableWrite,
                           bus8.oCa, bus8.oCb, bus8.oZero);
                end
            end
        end
    end

    initial begin : mon16
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (bus16.oValid === 1'b1) begin
                if (q16.size() == 0) begin
                    chk("spurious16.oValid",
                        {31'h0, bus16.oValid}, 32'h0);
                end else begin
                    e = q16.pop_front();
                    cmpOut(e, cyc, bus16.oData, bus16.oDataHi,
                           bus16.oWriteA, bus16.oWriteB,
                           bus16.oRamEnableWrite,
                           bus16.oCa, bus16.oCb, bus16.oZero);
                end
            end
        end
    end

    task automatic issue8(input logic [3:0] op, input logic dest,
                          input logic [7:0] a, b, input int lat,
                          input exp_t e);
        e.cyc = cyc + 1 + lat;
        q8.push_back(e);
        bus8.iValid = 1'b1;
        bus8.iOp    = op;
        bus8.iDest  = dest;
        bus8.iA     = a;
        bus8.iB     = b;
        @(posedge Clock);
        #1;
    endtask

    task automatic issue16(input logic [3:0] op, input logic dest,
                           input logic [15:0] a, b, input int lat,
                           input exp_t e);
        e.cyc = cyc + 1 + lat;
        q16.push_back(e);
        bus16.iValid = 1'b1;
        bus16.iOp    = op;
        bus16.iDest  = dest;
        bus16.iA     = a;
        bus16.iB     = b;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus8.iValid  = 1'b0;
        bus16.iValid = 1'b0;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        bus8.iValid  = 1'b0;
        bus8.iOp     = 4'd0;
        bus8.iDest   = 1'b0;
        bus8.iA      = 8'h0;
        bus8.iB      = 8'h0;
        bus16.iValid = 1'b0;
        bus16.iOp    = 4'd0;
        bus16.iDest  = 1'b0;
        bus16.iA     = 16'h0;
        bus16.iB     = 16'h0;
        idle(2);

        chk("rst.oReady", {31'h0, bus8.oReady}, 32'h1);
        chk("rst.oValid", {31'h0, bus8.oValid}, 32'h0);
        chk("rst.oData", {24'h0, bus8.oData}, 32'h0);
        chk("rst.oCa", {31'h0, bus8.oCa}, 32'h0);
        chk("rst.oCb", {31'h0, bus8.oCb}, 32'h0);
        chk("rst.oZero", {31'h0, bus8.oZero}, 32'h0);
        chk("rst.oWriteA", {31'h0, bus8.oWriteA}, 32'h0);
        chk("rst16.oReady", {31'h0, bus16.oReady}, 32'h1);
        Reset = 1'b1;
        idle(1);

        issue8(0, 0, 8'hF0, 8'h20, 0,
               ex("add", 'h10, 0, 1, 0, 0, 1, 0, 0));
        issue8(0, 0, 8'hFF, 8'h01, 0,
               ex("add0", 'h00, 0, 1, 0, 0, 1, 0, 1));
        issue8(1, 0, 8'h00, 8'h00, 0,
               ex("adc", 'h01, 0, 1, 0, 0, 0, 0, 0));
        issue8(2, 1, 8'h05, 8'h03, 0,
               ex("sub", 'hFE, 0, 0, 1, 0, 0, 1, 0));
        issue8(10, 0, 8'h03, 8'h03, 0,
               ex("cmp", 'h00, 0, 0, 0, 0, 0, 1, 1));
        issue8(3, 1, 8'h01, 8'h10, 0,
               ex("sbc", 'h0E, 0, 0, 1, 0, 0, 0, 0));
        issue8(0, 0, 8'h80, 8'h80, 0,
               ex("add80", 'h00, 0, 1, 0, 0, 1, 0, 1));
        issue8(4, 0, 8'hCC, 8'hAA, 0,
               ex("and", 'h88, 0, 1, 0, 0, 1, 0, 0));
        issue8(5, 1, 8'hF0, 8'h0F, 0,
               ex("or", 'hFF, 0, 0, 1, 0, 1, 0, 0));
        issue8(6, 0, 8'hFF, 8'h0F, 0,
               ex("xor", 'hF0, 0, 1, 0, 0, 1, 0, 0));
        issue8(7, 0, 8'h81, 8'h00, 0,
               ex("asl", 'h02, 0, 1, 0, 0, 1, 0, 0));
        issue8(8, 0, 8'h81, 8'h00, 0,
               ex("lsr", 'h40, 0, 1, 0, 0, 1, 0, 0));
        issue8(9, 0, 8'h81, 8'h00, 0,
               ex("rol", 'h03, 0, 1, 0, 0, 1, 0, 0));
        issue8(11, 0, 8'h5A, 8'h00, 0,
               ex("sta", 'h5A, 0, 0, 0, 1, 1, 0, 0));
        issue8(13, 1, 8'h12, 8'h34, 0,
               ex("nop", 'h00, 0, 0, 0, 0, 1, 0, 1));
        issue8(10, 0, 8'h07, 8'h03, 0,
               ex("cmp2", 'h04, 0, 0, 0, 0, 0, 0, 0));
        idle(1);

        issue8(12, 0, 8'hFF, 8'hFF, 9,
               ex("mul", 'h01, 'hFE, 1, 0, 0, 1, 0, 0));
        e = ex("held", 'h02, 0, 0, 1, 0, 1, 0, 0);
        e.cyc = cyc + 10;
        q8.push_back(e);
        bus8.iValid = 1'b1;
        bus8.iOp    = 4'd0;
        bus8.iDest  = 1'b1;
        bus8.iA     = 8'h01;
        bus8.iB     = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("mul.busy%0d.oReady", i),
                {31'h0, bus8.oReady}, 32'h0);
        end
        @(posedge Clock);
        #1;
        chk("mul.done.oReady", {31'h0, bus8.oReady}, 32'h1);
        @(posedge Clock);
        #1;
        idle(1);

        issue8(12, 1, 8'h0D, 8'h0B, 9,
               ex("mul2", 'h8F, 'h00, 0, 1, 0, 1, 0, 0));
        idle(10);

        bus8.iValid = 1'b1;
        bus8.iOp    = 4'd12;
        bus8.iDest  = 1'b0;
        bus8.iA     = 8'hFF;
        bus8.iB     = 8'hFF;
        @(posedge Clock);
        #1;
        idle(3);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort.oReady", {31'h0, bus8.oReady}, 32'h1);
        chk("abort.oValid", {31'h0, bus8.oValid}, 32'h0);
        chk("abort.oData", {24'h0, bus8.oData}, 32'h0);
        chk("abort.oDataHi", {24'h0, bus8.oDataHi}, 32'h0);
        chk("abort.oCa", {31'h0, bus8.oCa}, 32'h0);
        chk("abort.oCb", {31'h0, bus8.oCb}, 32'h0);
        chk("abort.oZero", {31'h0, bus8.oZero}, 32'h0);
        #3;
        Reset = 1'b1;
        idle(14);
        chk("abort.after.oReady", {31'h0, bus8.oReady}, 32'h1);

        issue8(0, 0, 8'h01, 8'h02, 0,
               ex("postrst", 'h03, 0, 1, 0, 0, 0, 0, 0));
        idle(1);

        issue16(0, 0, 16'hFFFF, 16'h0001, 0,
                ex("w16add", 'h0000, 0, 1, 0, 0, 1, 0, 1));
        issue16(12, 1, 16'h0100, 16'h0100, 17,
                ex("w16mul", 'h0000, 'h0001, 0, 1, 0, 1, 1, 1));
        idle(20);

        chk("pending8", q8.size(), 32'h0);
        chk("pending16", q16.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the datapath ALU. It executes one instruction per valid/ready handshake on W-bit operands A and B.
- It holds per-accumulator carry flags Ca/Cb across instructions, so it supports add-with-carry and subtract-with-borrow chains.
- It adds a multi-cycle shift-add multiplier with a 2W-bit result.
- It sits between the instruction decoder/register file (A, B accumulators) and the write-back/RAM-store path.

Parameters:
- W, 8: operand and result width; legal range 4..32.
- CNT_W, 6: multiplier iteration counter width; must satisfy 2^CNT_W > W.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iValid  in  1  instruction present.
- oReady  out  1  block can accept an instruction this cycle.
- iOp  in  4  opcode (encoding below).
- iDest  in  1  0 = accumulator A is destination/primary, 1 = B.
- iA  in  W  accumulator A value.
- iB  in  W  accumulator B value.
- oValid  out  1  one-cycle pulse, result outputs valid.
- oData  out  W  result, low word.
- oDataHi  out  W  high word (MUL only, else 0).
- oWriteA  out  1  write oData to A (qualified by oValid).
- oWriteB  out  1  write oData to B (qualified by oValid).
- oRamEnableWrite  out  1  store oData to RAM (qualified by oValid).
- oCa  out  1  carry flag A.
- oCb  out  1  carry flag B.
- oZero  out  1  oData == 0.

Behaviour:
- Reset low, asynchronous: state IDLE; all outputs 0 except oReady=1; Ca=Cb=0; counter=0. Reset mid-multiply aborts with no oValid.
- Accept: on a rising edge where iValid && oReady. Operands and op are latched. Inputs are ignored while oReady=0.
- Operand roles: P = primary (iDest=0: P=A, Q=B; iDest=1: P=B, Q=A). C = carry flag of the destination.
- Opcodes:
  - 0 ADD: {c,r} = P+Q.
  - 1 ADC: {c,r} = P+Q+C.
  - 2 SUB: r = P-Q; c = borrow (P<Q).
  - 3 SBC: r = P-Q-C; c = borrow.
  - 4 AND, 5 OR, 6 XOR: r = P op Q; carry preserved.
  - 7 ASL: r = P<<1; c = P[W-1].
  - 8 LSR: r = P>>1; c = P[0].
  - 9 ROL: r = {P[W-2:0],C}; c = P[W-1].
  - 10 CMP: as SUB but no register write; destination carry updated.
  - 11 STA: r = P; oRamEnableWrite=1; no register write; carries preserved.
  - 12 MUL: {hi,lo} = P*Q unsigned; c = |hi.
  - 13-15 NOP: r = 0; no writes; oValid still pulses.
- Write enables: oWriteA = (iDest==0), oWriteB = (iDest==1), for ops 0-9 and 12 only. All write enables are 0 when oValid=0.
- Flag update: only the destination's flag changes. The other flag always holds. Flags update on the same edge that raises oValid.
- Single-cycle ops (all except MUL): oValid=1 in the cycle after the acceptance edge; oReady stays 1. Back-to-back acceptance gives one result per cycle. ADC/SBC use the flag as updated by the immediately preceding instruction, with no bubble.
- MUL FSM: IDLE -> MUL on acceptance. oReady=0 while in MUL. Each cycle: if multiplier bit is set, add the shifted multiplicand into the 2W accumulator; shift; counter++. After W iterations go to DONE. DONE lasts 1 cycle: oValid=1, oReady=1, then IDLE. Acceptance in DONE is allowed. Latency: oValid at edge k+W+1 for acceptance at edge k.
- Outputs registered; they hold their last values when oValid=0. oDataHi is 0 for all non-MUL results.
- Widths: all arithmetic is computed W+1 bits wide (carry) or 2W bits wide (MUL). Wrap-around modulo 2^W on oData.

Test Plan:
- W=8, reset, then ADD A=0xF0 B=0x20 dest A -> oValid next cycle, oData=0x10, oCa=1, oCb=0, oWriteA=1.
- ADC chain: ADD A=0xFF B=0x01 (r=0x00, Ca=1, oZero=1) then ADC A=0x00 B=0x00 back-to-back -> oData=0x01, Ca=0.
- SUB dest B, A=0x05 B=0x03 -> r=B-A=0xFE, Cb=1, Ca unchanged; then CMP dest A, A=0x03 B=0x03 -> oZero=1, no write enables, Ca=0.
- MUL A=0xFF B=0xFF -> oReady low 8 cycles, oValid at acceptance+9, oData=0x01, oDataHi=0xFE, Ca=1; iValid held high during busy is not accepted.
- ASL/LSR/ROL on 0x81 with Ca=1 -> 0x02/c=1, 0x40/c=1, 0x03/c=1; STA A=0x5A -> oRamEnableWrite=1, oData=0x5A, flags held.
- Reset asserted mid-MUL (cycle 4) -> outputs 0 immediately, oReady=1, no oValid after release; W=16 regression of ADD 0xFFFF+0x0001 -> 0x0000, carry=1.
